// File: rtl/button_conditioner.sv
// Purpose: synchronise, debounce and edge-detect raw push-button / switch inputs.
// Latency: an input change that holds is committed DEBOUNCE_CYCLES+3 clk edges after it appears.
// Backpressure: none; level, pulse and toggle outputs are free-running registered values.
module button_conditioner #(
   parameter int                N_BTN           = 4,
   parameter int                DEBOUNCE_CYCLES = 1000000,
   parameter int                CNT_W           = 20,
   parameter logic [N_BTN-1:0]  TOGGLE_MASK     = N_BTN'(1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_rise,
   output logic [N_BTN-1:0] btn_fall,
   output logic [N_BTN-1:0] btn_toggle
);

   // Terminal count: a candidate value is accepted when it is still present
   // with the counter sitting here.
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_LOW      = 2'd0,
      S_LOW_CHK  = 2'd1,
      S_HIGH     = 2'd2,
      S_HIGH_CHK = 2'd3
   } state_t;

   logic [N_BTN-1:0] sync1;
   logic [N_BTN-1:0] sync2;

   // Two-flop synchroniser on every channel; only sync2 is used downstream.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn_in;
         sync2 <= sync1;
      end
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      state_t           state;
      state_t           state_nxt;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] cnt_nxt;
      logic             commit_press;
      logic             commit_release;
      logic             level_q;
      logic             level_nxt;
      logic             rise_q;
      logic             fall_q;
      logic             toggle_q;
      logic             toggle_nxt;

      // State and hold-counter register.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state <= S_LOW;
            cnt   <= '0;
         end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
         end
      end

      // Next-state logic: a candidate value must survive to the terminal
      // count; any reversion during the check window is treated as bounce.
      always_comb begin
         state_nxt      = state;
         cnt_nxt        = cnt;
         commit_press   = 1'b0;
         commit_release = 1'b0;
         case (state)
            S_LOW: begin
               if (sync2[i]) begin
                  state_nxt = S_LOW_CHK;
                  cnt_nxt   = '0;
               end
            end
            S_LOW_CHK: begin
               if (!sync2[i]) begin
                  state_nxt = S_LOW;
                  cnt_nxt   = '0;
               end else if (cnt == CNT_MAX) begin
                  state_nxt    = S_HIGH;
                  cnt_nxt      = '0;
                  commit_press = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            S_HIGH: begin
               if (!sync2[i]) begin
                  state_nxt = S_HIGH_CHK;
                  cnt_nxt   = '0;
               end
            end
            S_HIGH_CHK: begin
               if (sync2[i]) begin
                  state_nxt = S_HIGH;
                  cnt_nxt   = '0;
               end else if (cnt == CNT_MAX) begin
                  state_nxt      = S_LOW;
                  cnt_nxt        = '0;
                  commit_release = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            default: begin
               state_nxt = S_LOW;
               cnt_nxt   = '0;
            end
         endcase
      end

      // Output decode: next level and toggle values from the commit strobes.
      // Unmasked channels never flip, so their toggle stays at its reset 0.
      always_comb begin
         level_nxt = level_q;
         if (commit_press) begin
            level_nxt = 1'b1;
         end else if (commit_release) begin
            level_nxt = 1'b0;
         end
         toggle_nxt = toggle_q ^ (commit_press & TOGGLE_MASK[i]);
      end

      // Output register: keeps every output free of paths from btn_in and
      // makes the rise/fall strobes exactly one cycle wide.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            toggle_q <= 1'b0;
         end else begin
            level_q  <= level_nxt;
            rise_q   <= commit_press;
            fall_q   <= commit_release;
            toggle_q <= toggle_nxt;
         end
      end

      assign btn_level[i]  = level_q;
      assign btn_rise[i]   = rise_q;
      assign btn_fall[i]   = fall_q;
      assign btn_toggle[i] = toggle_q;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: directed stimulus with a scoreboard of
// expected rise/fall events and a monitor that checks every cycle.
module tb_button_conditioner;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn_in;
   logic [3:0] btn_level;
   logic [3:0] btn_rise;
   logic [3:0] btn_fall;
   logic [3:0] btn_toggle;

   logic [3:0] btn_in1;
   logic [3:0] level1;
   logic [3:0] rise1;
   logic [3:0] fall1;
   logic [3:0] toggle1;

   always #5 clk = ~clk;

   button_conditioner #(
      .N_BTN(4), .DEBOUNCE_CYCLES(4), .CNT_W(3), .TOGGLE_MASK(4'b0001)
   ) u_dut (
      .clk(clk), .rst(rst), .btn_in(btn_in),
      .btn_level(btn_level), .btn_rise(btn_rise),
      .btn_fall(btn_fall), .btn_toggle(btn_toggle)
   );

   button_conditioner #(
      .N_BTN(4), .DEBOUNCE_CYCLES(1), .CNT_W(1), .TOGGLE_MASK(4'b0001)
   ) u_dut1 (
      .clk(clk), .rst(rst), .btn_in(btn_in1),
      .btn_level(level1), .btn_rise(rise1),
      .btn_fall(fall1), .btn_toggle(toggle1)
   );

   typedef struct {
      int         cyc;
      logic [3:0] rise;
      logic [3:0] fall;
      logic [3:0] level;
      logic [3:0] toggle;
   } ev_t;

   ev_t        exp_q[$];
   ev_t        mon_ev;
   ev_t        left_ev;
   int         edge_cnt = 0;
   int         n_checks = 0;
   int         n_fail   = 0;
   logic [3:0] exp_level  = 4'b0000;
   logic [3:0] exp_toggle = 4'b0000;
   int         e0;

   always @(posedge clk) edge_cnt++;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %b, want %b", name, edge_cnt, act, req);
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, req);
      end
   endtask

   task automatic expect_ev(input int cyc, input logic [3:0] r, input logic [3:0] f,
                            input logic [3:0] l, input logic [3:0] t);
      ev_t ev;
      ev.cyc = cyc; ev.rise = r; ev.fall = f; ev.level = l; ev.toggle = t;
      exp_q.push_back(ev);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: pops an expected event whenever a pulse shows up, flags
   // expected events that never arrived, and checks level/toggle every cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            exp_level  = 4'b0000;
            exp_toggle = 4'b0000;
         end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < edge_cnt) begin
               mon_ev = exp_q.pop_front();
               n_checks++;
               n_fail++;
               $display("FAIL missed_event: want rise %b fall %b at edge %0d, none by edge %0d",
                        mon_ev.rise, mon_ev.fall, mon_ev.cyc, edge_cnt);
               exp_level  = mon_ev.level;
               exp_toggle = mon_ev.toggle;
            end
            if ((btn_rise | btn_fall) != 4'b0000) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_pulse at edge %0d: got rise %b fall %b, want none",
                           edge_cnt, btn_rise, btn_fall);
               end else begin
                  mon_ev = exp_q.pop_front();
                  check_int("event_edge", edge_cnt, mon_ev.cyc);
                  check("event_rise", btn_rise, mon_ev.rise);
                  check("event_fall", btn_fall, mon_ev.fall);
                  exp_level  = mon_ev.level;
                  exp_toggle = mon_ev.toggle;
               end
            end
            check("level", btn_level, exp_level);
            check("toggle", btn_toggle, exp_toggle);
         end
      end
   end

   initial begin
      rst     = 1'b1;
      btn_in  = 4'b0000;
      btn_in1 = 4'b0000;
      #1 rst = 1'b0;
      #1;
      check("reset_level", btn_level, 4'b0000);
      check("reset_rise", btn_rise, 4'b0000);
      check("reset_fall", btn_fall, 4'b0000);
      check("reset_toggle", btn_toggle, 4'b0000);
      cycles(3);
      rst = 1'b1;
      cycles(3);

      // Clean press and release on channel 1 (not toggle-enabled).
      btn_in[1] = 1'b1;
      expect_ev(edge_cnt + 7, 4'b0010, 4'b0000, 4'b0010, 4'b0000);
      cycles(12);
      btn_in[1] = 1'b0;
      expect_ev(edge_cnt + 7, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
      cycles(12);

      // Bounce on channel 2: 3 high, 1 low, 2 high, then low; never accepted.
      btn_in[2] = 1'b1; cycles(3);
      btn_in[2] = 1'b0; cycles(1);
      btn_in[2] = 1'b1; cycles(2);
      btn_in[2] = 1'b0; cycles(12);

      // Two press/release pairs on channel 0 flip the toggle on then off.
      for (int k = 0; k < 2; k++) begin
         btn_in[0] = 1'b1;
         expect_ev(edge_cnt + 7, 4'b0001, 4'b0000, 4'b0001, (k == 0) ? 4'b0001 : 4'b0000);
         cycles(10);
         btn_in[0] = 1'b0;
         expect_ev(edge_cnt + 7, 4'b0000, 4'b0001, 4'b0000, (k == 0) ? 4'b0001 : 4'b0000);
         cycles(10);
      end

      // All channels rise together.
      btn_in = 4'b1111;
      expect_ev(edge_cnt + 7, 4'b1111, 4'b0000, 4'b1111, 4'b0001);
      cycles(10);
      btn_in = 4'b0000;
      expect_ev(edge_cnt + 7, 4'b0000, 4'b1111, 4'b0000, 4'b0001);
      cycles(10);

      // Reset mid-count on channel 3 while channel 1 is high and toggle[0] is set.
      btn_in[1] = 1'b1;
      expect_ev(edge_cnt + 7, 4'b0010, 4'b0000, 4'b0010, 4'b0001);
      cycles(10);
      btn_in[3] = 1'b1;
      repeat (5) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("midrst_level", btn_level, 4'b0000);
      check("midrst_rise", btn_rise, 4'b0000);
      check("midrst_fall", btn_fall, 4'b0000);
      check("midrst_toggle", btn_toggle, 4'b0000);
      cycles(3);
      rst = 1'b1;
      expect_ev(edge_cnt + 7, 4'b1010, 4'b0000, 4'b1010, 4'b0000);
      cycles(10);
      btn_in = 4'b0000;
      expect_ev(edge_cnt + 7, 4'b0000, 4'b1010, 4'b0000, 4'b0000);
      cycles(10);

      // Single-cycle debounce build: commit at edge 4 after the change.
      btn_in1[0] = 1'b1;
      e0 = edge_cnt;
      cycles(3);
      check_int("dc1_edge_pre", edge_cnt, e0 + 3);
      check("dc1_rise_early", rise1, 4'b0000);
      check("dc1_level_early", level1, 4'b0000);
      cycles(1);
      check("dc1_rise", rise1, 4'b0001);
      check("dc1_level", level1, 4'b0001);
      check("dc1_toggle", toggle1, 4'b0001);
      cycles(1);
      check("dc1_rise_clear", rise1, 4'b0000);
      btn_in1[0] = 1'b0;
      cycles(4);
      check("dc1_fall", fall1, 4'b0001);
      check("dc1_level_low", level1, 4'b0000);
      cycles(1);
      check("dc1_fall_clear", fall1, 4'b0000);

      cycles(5);
      while (exp_q.size() > 0) begin
         left_ev = exp_q.pop_front();
         n_checks++;
         n_fail++;
         $display("FAIL unconsumed_event: want rise %b fall %b at edge %0d, never seen",
                  left_ev.rise, left_ev.fall, left_ev.cyc);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Input-conditioning stage directly upstream of the stopwatch top level. It takes raw, bouncing push-button and switch inputs (pause, rst, select, adjust) and first synchronises each one to clk. It then debounces each one with its own per-channel state machine. It produces a clean level, single-cycle press and release pulses, and an optional press-toggled latch (used for pause run/stop), which feed the stopwatch and display inputs.

Parameters:
N_BTN, 4, number of independent input channels
DEBOUNCE_CYCLES, 1000000, clk cycles an input must hold a new value before it is accepted (10 ms at 100 MHz); legal range >= 1
CNT_W, 20, counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES
TOGGLE_MASK, 4'b0001, bit i = 1 makes btn_toggle[i] flip on each accepted press of channel i; 0 holds btn_toggle[i] at 0

Ports:
clk  input  1  main clock
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
btn_in  input  N_BTN  raw asynchronous button/switch inputs, active-high
btn_level  output  N_BTN  debounced level per channel
btn_rise  output  N_BTN  one-cycle pulse on accepted 0->1 transition
btn_fall  output  N_BTN  one-cycle pulse on accepted 1->0 transition
btn_toggle  output  N_BTN  press-toggled latch for channels selected by TOGGLE_MASK

Behaviour:
- Reset (rst=0, async): clears all sync flops, counters, FSMs and outputs to 0. Outputs go 0 without waiting for a clk edge. Reset takes effect in any state, including mid-count.
- Synchroniser: 2-flop chain per channel; the FSM sees only sync2.
- Per-channel FSM, 4 states:
  - S_LOW: stable 0. sync2=1 -> S_LOW_CHK, cnt<=0.
  - S_LOW_CHK: candidate 1.
    - sync2=0 -> S_LOW, cnt<=0; no output change (glitch rejected).
    - sync2=1 and cnt==DEBOUNCE_CYCLES-1 -> S_HIGH, commit press.
    - Otherwise cnt<=cnt+1.
  - S_HIGH: stable 1. sync2=0 -> S_HIGH_CHK, cnt<=0.
  - S_HIGH_CHK: mirror of S_LOW_CHK.
    - sync2=1 -> S_HIGH (glitch rejected).
    - sync2=0 and cnt==DEBOUNCE_CYCLES-1 -> S_LOW, commit release.
- Commit press:
  - btn_level<=1 and btn_rise<=1 on the same edge.
  - btn_toggle<=~btn_toggle if TOGGLE_MASK bit set.
  - btn_rise is high for exactly one cycle.
- Commit release: btn_level<=0, btn_fall<=1 for exactly one cycle; btn_toggle unchanged.
- Latency: if btn_in changes before clk edge 1 and holds, the sync flops capture it at edges 1-2 and CHK is entered at edge 3. The commit edge is 3+DEBOUNCE_CYCLES. Outputs are registered with no combinational path from btn_in.
- Counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- btn_rise and btn_fall are never both high on one channel.
- Channels are fully independent; simultaneous commits on several channels in the same cycle are allowed.
- Input held high through reset release: no suppression. The full press sequence runs and btn_rise fires at edge 3+DEBOUNCE_CYCLES after release.
- btn_toggle for unmasked channels is constant 0.

Test Plan:
(Bench uses N_BTN=4, DEBOUNCE_CYCLES=4, TOGGLE_MASK=4'b0001.)
- Clean press: btn_in[1] 0->1 before edge 1, held.
  - btn_level[1]=1 and btn_rise[1]=1 after edge 7; btn_rise[1]=0 after edge 8.
  - btn_toggle[1] stays 0; other channels unaffected.
- Bounce rejection: btn_in[2] high 3 cycles, low 1 cycle, high 2 cycles, then low.
  - btn_level[2], btn_rise[2], btn_fall[2] remain 0 throughout.
- Toggle: two separate clean presses and releases on btn_in[0].
  - btn_toggle[0]=1 after first commit, 0 after second.
  - btn_fall[0] pulses once per release, 7 edges after btn_in[0] falls.
- Reset mid-operation: btn_in[3] high, rst=0 asserted between clk edges after edge 5.
  - All outputs 0 immediately.
  - rst=1 with btn_in[3] still high -> btn_level[3]=1 and btn_rise[3] pulse at edge 7 after release.
- Simultaneous: btn_in=4'b1111 rises on one edge -> all four btn_rise bits pulse in the same cycle; btn_toggle=4'b0001.
- Max count: DEBOUNCE_CYCLES=1 build; clean press -> commit at edge 4; counter never exceeds 0.
